// File: rtl/probit_window_accumulator.sv
// Multi-channel gt/lt probit window accumulator with handshaked readout.
// Optional drop counter: define PROBIT_DROP_COUNT_EN to add drop_cnt_o.
module probit_window_accumulator #(
  parameter int    NCHAN   = 8,
  parameter int    NSAMP   = 8,
  parameter int    PERIOD  = 131072,
  parameter string CLKTYPE = "NONE",
  localparam int   NBITS   = $clog2(PERIOD*NSAMP+1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic                   cont_i,
  input  logic [NCHAN*NSAMP-1:0] gt_i,
  input  logic [NCHAN*NSAMP-1:0] lt_i,
  output logic [NCHAN*NBITS-1:0] gt_sum_o,
  output logic [NCHAN*NBITS-1:0] lt_sum_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   busy_o,
  output logic                   overrun_o
`ifdef PROBIT_DROP_COUNT_EN
  ,
  output logic [15:0]            drop_cnt_o
`endif
);

  localparam int PW = $clog2(NSAMP+1);
  localparam int CW = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LOAD = CW'(PERIOD-1);

  generate
    if (!(NSAMP == 4 || NSAMP == 8 || NSAMP == 16)) begin : g_bad_nsamp
      $error("NSAMP must be 4, 8 or 16");
    end
    if (PERIOD < 2) begin : g_bad_period
      $error("PERIOD must be at least 2");
    end
  endgenerate

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_cont;
  logic             r_busy;
  logic             w_run;

  logic [NCHAN*PW-1:0] w_pc_gt;
  logic [NCHAN*PW-1:0] w_pc_lt;
  logic [NCHAN*PW-1:0] r_pc_gt;
  logic [NCHAN*PW-1:0] r_pc_lt;
  logic                r_s1_vld;
  logic                r_s1_first;
  logic                r_s1_last;

  logic [NCHAN*NBITS-1:0] r_acc_gt;
  logic [NCHAN*NBITS-1:0] r_acc_lt;
  logic                   r_s2_done;

  (* CUSTOM_CC_SRC = CLKTYPE *) logic [NCHAN*NBITS-1:0] r_hold_gt;
  (* CUSTOM_CC_SRC = CLKTYPE *) logic [NCHAN*NBITS-1:0] r_hold_lt;
  logic                   r_valid;
  logic                   r_ovr;
  logic                   w_drop;

  assign w_run  = (r_state == S_RUN);
  assign w_drop = r_s2_done & r_valid & ~ready_i;

  // Window sequencer: run/idle state and the per-window clock counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_cont  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state <= S_RUN;
            r_cont  <= cont_i;
            r_cnt   <= LOAD;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (stop_i) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (r_cnt == '0) begin
            if (r_cont) begin
              r_cnt <= LOAD;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Per-channel popcount of the comparator bits.
  always_comb begin
    w_pc_gt = '0;
    w_pc_lt = '0;
    for (int c = 0; c < NCHAN; c++) begin
      for (int b = 0; b < NSAMP; b++) begin
        w_pc_gt[c*PW +: PW] = w_pc_gt[c*PW +: PW]
                            + PW'(gt_i[c*NSAMP+b]);
        w_pc_lt[c*PW +: PW] = w_pc_lt[c*PW +: PW]
                            + PW'(lt_i[c*NSAMP+b]);
      end
    end
  end

  // Stage 1: register popcounts and tag the sample's window position.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pc_gt    <= '0;
      r_pc_lt    <= '0;
      r_s1_vld   <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
    end else begin
      r_pc_gt    <= w_pc_gt;
      r_pc_lt    <= w_pc_lt;
      r_s1_vld   <= w_run & ~stop_i;
      r_s1_first <= w_run & (r_cnt == LOAD);
      r_s1_last  <= w_run & ~stop_i & (r_cnt == '0);
    end
  end

  // Stage 2: accumulate; the first sample of a window overwrites.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_acc_gt  <= '0;
      r_acc_lt  <= '0;
      r_s2_done <= 1'b0;
    end else begin
      r_s2_done <= r_s1_vld & r_s1_last;
      if (r_s1_vld) begin
        for (int c = 0; c < NCHAN; c++) begin
          if (r_s1_first) begin
            r_acc_gt[c*NBITS +: NBITS] <= NBITS'(r_pc_gt[c*PW +: PW]);
            r_acc_lt[c*NBITS +: NBITS] <= NBITS'(r_pc_lt[c*PW +: PW]);
          end else begin
            r_acc_gt[c*NBITS +: NBITS] <= r_acc_gt[c*NBITS +: NBITS]
                                        + NBITS'(r_pc_gt[c*PW +: PW]);
            r_acc_lt[c*NBITS +: NBITS] <= r_acc_lt[c*NBITS +: NBITS]
                                        + NBITS'(r_pc_lt[c*PW +: PW]);
          end
        end
      end
    end
  end

  // Holding bank and readout handshake; a full, unready bank drops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hold_gt <= '0;
      r_hold_lt <= '0;
      r_valid   <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_ovr <= w_drop;
      if (r_s2_done) begin
        if (!r_valid || ready_i) begin
          r_hold_gt <= r_acc_gt;
          r_hold_lt <= r_acc_lt;
          r_valid   <= 1'b1;
        end
      end else if (r_valid && ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef PROBIT_DROP_COUNT_EN
  logic [15:0] r_drop;

  // Saturating count of dropped windows, cleared on each new run.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_drop <= '0;
    end else if (r_state == S_IDLE && start_i) begin
      r_drop <= '0;
    end else if (w_drop && r_drop != 16'hFFFF) begin
      r_drop <= r_drop + 16'd1;
    end
  end

  assign drop_cnt_o = r_drop;
`endif

  assign gt_sum_o  = r_hold_gt;
  assign lt_sum_o  = r_hold_lt;
  assign valid_o   = r_valid;
  assign busy_o    = r_busy;
  assign overrun_o = r_ovr;

endmodule

// File: tb/tb_probit_window_accumulator.sv
// Bench for probit_window_accumulator: directed and random windows
// checked against sums recomputed from recorded input history.
module tb_probit_window_accumulator;

  localparam int NCHAN  = 2;
  localparam int NSAMP  = 8;
  localparam int PERIOD = 16;
  localparam int NBITS  = $clog2(PERIOD*NSAMP+1);
  localparam int W      = NCHAN*NSAMP;
  localparam int SW     = NCHAN*NBITS;
  localparam int HMAX   = 4096;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, stop, cont, ready;
  logic [W-1:0]  gt, lt;
  logic [SW-1:0] gt_sum, lt_sum;
  logic          valid, busy, overrun;
`ifdef PROBIT_DROP_COUNT_EN
  logic [15:0]   drop_cnt;
`endif

  int n_pass = 0;
  int n_tot  = 0;

  probit_window_accumulator #(
    .NCHAN(NCHAN), .NSAMP(NSAMP), .PERIOD(PERIOD), .CLKTYPE("NONE")
  ) dut (
`ifdef PROBIT_DROP_COUNT_EN
    .drop_cnt_o(drop_cnt),
`endif
    .clk_i(clk), .rst_ni(rst_n),
    .start_i(start), .stop_i(stop), .cont_i(cont),
    .gt_i(gt), .lt_i(lt),
    .gt_sum_o(gt_sum), .lt_sum_o(lt_sum),
    .valid_o(valid), .ready_i(ready),
    .busy_o(busy), .overrun_o(overrun)
  );

  always #5 clk = ~clk;

  // Input history per clock edge.
  logic [W-1:0] hg [HMAX];
  logic [W-1:0] hl [HMAX];
  int ecnt = 0;
  int last_edge = -1;

  always @(posedge clk) begin
    if (ecnt < HMAX) begin
      hg[ecnt] = gt;
      hl[ecnt] = lt;
    end
    last_edge = ecnt;
    ecnt++;
  end

  // Window starting after edge c0: sum popcounts of edges c0+1..c0+PERIOD.
  function automatic logic [SW-1:0] model(input int c0, input bit g);
    logic [SW-1:0] r;
    logic [W-1:0]  v;
    int s;
    r = '0;
    for (int ch = 0; ch < NCHAN; ch++) begin
      s = 0;
      for (int e = c0 + 1; e <= c0 + PERIOD; e++) begin
        v = g ? hg[e] : hl[e];
        s += $countones(v[ch*NSAMP +: NSAMP]);
      end
      r[ch*NBITS +: NBITS] = NBITS'(s);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_in();
    gt = W'($urandom);
    lt = W'($urandom);
  endtask

  task automatic start_win(input logic c, output int c0);
    start = 1'b1;
    cont  = c;
    step();
    c0    = last_edge;
    start = 1'b0;
    cont  = 1'b0;
  endtask

  task automatic wait_valid(input int c0, input string tag);
    int n;
    int lat;
    n   = 0;
    lat = -1;
    while (!valid && n < 64) begin
      step();
      n++;
    end
    if (valid) lat = last_edge - c0;
    chk(tag, 64'(lat), 64'(18));
  endtask

  logic [SW-1:0] s16;
  logic [SW-1:0] s128;
  logic [SW-1:0] s3;

  initial begin
    int c0;
    int c2;
    int n_ov;
    int ov_e;
    int n_v;
    logic [SW-1:0] w1_gt;

    s16  = {NCHAN{NBITS'(16)}};
    s128 = {NCHAN{NBITS'(128)}};
    s3   = '0;
    s3[NBITS-1:0] = NBITS'(3);

    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    cont  = 1'b0;
    ready = 1'b0;
    gt    = '0;
    lt    = '0;
    repeat (3) step();
    chk("rst_valid", 64'(valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_ovr", 64'(overrun), 64'(0));
    chk("rst_gt", 64'(gt_sum), 64'(0));
    chk("rst_lt", 64'(lt_sum), 64'(0));
    rst_n = 1'b1;
    step();

    // Single window, all gt ones.
    gt = '1;
    lt = '0;
    ready = 1'b1;
    start_win(1'b0, c0);
    chk("t1_busy", 64'(busy), 64'(1));
    wait_valid(c0, "t1_lat");
    chk("t1_gt", 64'(gt_sum), 64'(s128));
    chk("t1_lt", 64'(lt_sum), 64'(0));
    chk("t1_model", 64'(gt_sum), 64'(model(c0, 1'b1)));
    chk("t1_busy_end", 64'(busy), 64'(0));
    step();
    chk("t1_consumed", 64'(valid), 64'(0));

    // Window boundary alignment.
    gt = '1;
    lt = '1;
    start_win(1'b0, c0);
    gt = W'(16'h0007);
    lt = '0;
    step();
    gt = '0;
    repeat (PERIOD - 1) step();
    gt = '1;
    lt = '1;
    step();
    gt = '0;
    lt = '0;
    wait_valid(c0, "t2_lat");
    chk("t2_gt", 64'(gt_sum), 64'(s3));
    chk("t2_lt", 64'(lt_sum), 64'(0));
    step();

    // Continuous with no consumer: overrun.
    gt = W'(16'h0101);
    lt = '0;
    ready = 1'b0;
    n_ov = 0;
    ov_e = -1;
    start_win(1'b1, c0);
    for (int k = 1; k <= 35; k++) begin
      step();
      if (overrun) begin
        n_ov++;
        ov_e = last_edge - c0;
      end
      if (k == 18) begin
        chk("t3_valid1", 64'(valid), 64'(1));
        chk("t3_sum1", 64'(gt_sum), 64'(s16));
      end
    end
    chk("t3_nov", 64'(n_ov), 64'(1));
    chk("t3_ov_edge", 64'(ov_e), 64'(34));
    chk("t3_hold", 64'(gt_sum), 64'(s16));
    chk("t3_valid", 64'(valid), 64'(1));
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("t3_busy", 64'(busy), 64'(0));
`ifdef PROBIT_DROP_COUNT_EN
    chk("t3_drop", 64'(drop_cnt), 64'(1));
`endif
    ready = 1'b1;
    step();
    chk("t3_clear", 64'(valid), 64'(0));

    // Continuous, handshake on window-2 completion clock.
    ready = 1'b0;
    n_ov = 0;
    rnd_in();
    start_win(1'b1, c0);
    for (int k = 1; k <= 35; k++) begin
      rnd_in();
      ready = (k == 34);
      stop  = (k == 35);
      step();
      if (overrun) n_ov++;
      if (k == 18) chk("t4_valid1", 64'(valid), 64'(1));
      if (k == 33) begin
        w1_gt = model(c0, 1'b1);
        chk("t4_w1_gt", 64'(gt_sum), 64'(w1_gt));
        chk("t4_w1_lt", 64'(lt_sum), 64'(model(c0, 1'b0)));
      end
      if (k == 34) begin
        chk("t4_valid2", 64'(valid), 64'(1));
        chk("t4_w2_gt", 64'(gt_sum), 64'(model(c0 + PERIOD, 1'b1)));
        chk("t4_w2_lt", 64'(lt_sum), 64'(model(c0 + PERIOD, 1'b0)));
      end
    end
    stop  = 1'b0;
    ready = 1'b0;
    chk("t4_nov", 64'(n_ov), 64'(0));
    ready = 1'b1;
    step();
    chk("t4_clear", 64'(valid), 64'(0));

    // Abort then restart.
    ready = 1'b0;
    n_v = 0;
    rnd_in();
    start_win(1'b0, c0);
    for (int k = 1; k <= 30; k++) begin
      rnd_in();
      stop = (k == 8);
      step();
      if (valid) n_v++;
    end
    stop = 1'b0;
    chk("t5_no_valid", 64'(n_v), 64'(0));
    chk("t5_idle", 64'(busy), 64'(0));
    rnd_in();
    start_win(1'b0, c2);
    for (int k = 1; k <= 18; k++) begin
      rnd_in();
      step();
      if (k == 17) chk("t5_early", 64'(valid), 64'(0));
    end
    chk("t5_valid", 64'(valid), 64'(1));
    chk("t5_gt", 64'(gt_sum), 64'(model(c2, 1'b1)));
    chk("t5_lt", 64'(lt_sum), 64'(model(c2, 1'b0)));
    ready = 1'b1;
    step();
    chk("t5_clear", 64'(valid), 64'(0));

    // Async reset mid-window with a held result.
    ready = 1'b0;
    rnd_in();
    start_win(1'b1, c0);
    for (int k = 1; k <= 21; k++) begin
      rnd_in();
      step();
    end
    chk("t6_pre_valid", 64'(valid), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", 64'(valid), 64'(0));
    chk("t6_busy", 64'(busy), 64'(0));
    chk("t6_gt", 64'(gt_sum), 64'(0));
    chk("t6_lt", 64'(lt_sum), 64'(0));
    chk("t6_ovr", 64'(overrun), 64'(0));
`ifdef PROBIT_DROP_COUNT_EN
    chk("t6_drop0", 64'(drop_cnt), 64'(0));
`endif
    step();
    rst_n = 1'b1;
    step();
    gt = W'(16'h0101);
    lt = '0;
    n_ov = 0;
    start_win(1'b1, c0);
    for (int k = 1; k <= 51; k++) begin
      step();
      if (overrun) n_ov++;
    end
    chk("t6_nov", 64'(n_ov), 64'(2));
    chk("t6_hold", 64'(gt_sum), 64'(s16));
`ifdef PROBIT_DROP_COUNT_EN
    chk("t6_drop2", 64'(drop_cnt), 64'(2));
`endif
    stop = 1'b1;
    step();
    stop = 1'b0;
    ready = 1'b1;
    step();
    chk("t6_clear", 64'(valid), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/probit_window_accumulator.md
Name: probit_window_accumulator

Overview:
Multi-channel successor to the single-channel gt/lt probit accumulator. Accumulates the per-clock popcounts of NCHAN channels' gt and lt comparator bits over an internally timed window of PERIOD clocks. Completed window sums are latched into a holding bank and handed to the register/readout logic with a valid/ready handshake. Supports single-shot or gapless continuous windows, abort, and overrun detection.

Parameters:
NCHAN, 8, number of channels accumulated in parallel
NSAMP, 8, samples per clock per channel; legal values 4, 8, 16; anything else is an elaboration $error
PERIOD, 131072, window length in clocks; must be >= 2
NBITS, $clog2(PERIOD*NSAMP+1), derived localparam giving per-channel sum width; sums cannot wrap
CLKTYPE, "NONE", string applied as CUSTOM_CC_SRC to the holding registers

Ports:
clk_i  in  1  single clock
rst_ni  in  1  asynchronous, active-low reset
start_i  in  1  begin a window (honoured only in IDLE)
stop_i  in  1  abort the current window/run
cont_i  in  1  sampled with start_i: 1 = continuous back-to-back windows, 0 = single window
gt_i  in  NCHAN*NSAMP  greater-than bits; channel c occupies [c*NSAMP +: NSAMP]
lt_i  in  NCHAN*NSAMP  less-than bits; same packing
gt_sum_o  out  NCHAN*NBITS  held gt sums; channel c occupies [c*NBITS +: NBITS]
lt_sum_o  out  NCHAN*NBITS  held lt sums
valid_o  out  1  holding bank contains an unconsumed result
ready_i  in  1  consumer accepts the result
busy_o  out  1  state is RUN
overrun_o  out  1  one-clock pulse when a completed window is dropped

Behaviour:
- Reset (rst_ni low, asynchronous): state IDLE. All accumulators, holding sums, valid_o, busy_o and overrun_o are 0.
- Pipeline: stage 1 registers the per-channel popcounts of gt_i/lt_i. It is free-running, with no ce/reset gating other than rst_ni. Stage 2 is the accumulator.
- States:
  - IDLE: start_i=1 -> RUN. Latch cont_i. Load the clock counter with PERIOD-1.
  - RUN: counter decrements each clock.
    - At counter 0, the window closes. If single-shot, go to IDLE; if continuous, reload PERIOD-1 and stay in RUN.
    - stop_i=1 in RUN -> IDLE. The partial window is discarded and no valid is produced. stop_i has priority over window close in the same cycle.
    - start_i is ignored while in RUN.
- Window alignment: if start_i is sampled at edge C, the window contains the inputs present at edges C+1 through C+PERIOD.
  - The accumulator loads the first popcount directly at edge C+2; it does not add to the stale value.
  - Continuous windows are gapless: the next window covers edges C+PERIOD+1 through C+2*PERIOD.
- Result: the final sum is transferred to the holding bank at edge C+PERIOD+2. valid_o is high from that edge.
- Handshake:
  - valid_o clears on the edge after valid_o and ready_i are both high.
  - Holding sums are stable while valid_o=1.
  - ready_i with valid_o=0 has no effect.
- Overrun: a window completes while valid_o=1 and ready_i=0.
  - The new result is discarded and the holding bank keeps the old one.
  - overrun_o pulses for 1 clock.
- Simultaneous completion and handshake (valid_o and ready_i both high in the completion cycle): the new result loads, valid_o stays 1, and there is no overrun.
- Arithmetic: unsigned, with popcount width $clog2(NSAMP+1). The maximum sum is PERIOD*NSAMP, so sums never wrap.
- busy_o = (state == RUN), registered.

Optional Feature:
PROBIT_DROP_COUNT_EN
- Defined: adds output drop_cnt_o [15:0], counting dropped windows.
  - Saturates at 16'hFFFF.
  - Cleared by rst_ni and by each start_i accepted in IDLE.
- Undefined: port and counter are absent; overrun_o is still present.

Test Plan:
- NCHAN=2, NSAMP=8, PERIOD=16, all gt_i bits 1, lt_i=0, start_i with cont_i=0, ready_i=1 -> valid_o rises exactly 18 clocks after the start edge. gt_sum_o shows 128 per channel, lt_sum_o shows 0, and busy_o then deasserts.
- Channel 0 gt has 3 bits set on only the first window clock (edge C+1), and all other inputs are 0 -> result ch0 gt=3, all else 0. Stimulus toggling at edges C and C+PERIOD+1 is excluded from the window.
- Continuous mode with ready_i held 0 and constant 1 bit per channel -> first result 16; second window completion pulses overrun_o once, and the holding sum stays 16. Raising ready_i then clears valid_o the next clock.
- Continuous mode with ready_i asserted exactly on the completion clock of window 2 -> window-2 value loads, valid_o stays high, and there is no overrun_o pulse.
- stop_i at window clock 8, then a new start_i -> no valid from the aborted window. The new window result counts only its own 16 clocks, with no residue from the aborted window.
- rst_ni pulsed low mid-window with valid_o=1 -> all outputs 0 immediately (asynchronously) and state IDLE. With PROBIT_DROP_COUNT_EN, drop_cnt_o is 0 and later increments once per overrun.
